// File: rtl/serial_word_streamer.sv
// Serial word streamer: takes W-bit words over valid/ready and shifts them out MSB-first,
// pulsing fsm_rst one cycle before each word so the downstream divisibility FSMs restart.
module serial_word_streamer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         new_bit,
    output logic         bit_valid,
    output logic         last_bit,
    output logic         fsm_rst,
    output logic         busy
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

    state_t        state;
    state_t        next_state;
    logic [W-1:0]  hold_data;
    logic [W-1:0]  shift_reg;
    logic          hold_full;
    logic [CW-1:0] cnt;
    logic          word_end;
    logic          load;
    logic          accept;

    assign word_end = (state == SHIFT) && (cnt == LAST_CNT);
    assign load     = ((state == IDLE) || word_end) && hold_full;
    assign accept   = in_valid && !hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load) next_state = CLEAR;
            CLEAR:   next_state = SHIFT;
            SHIFT:   if (word_end) next_state = load ? CLEAR : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A load empties the holding register, so it can never coincide with an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            cnt       <= '0;
        end else if (load) begin
            shift_reg <= hold_data;
            hold_full <= 1'b0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                hold_data <= in_data;
                hold_full <= 1'b1;
            end
            if (state == SHIFT) begin
                shift_reg <= shift_reg << 1;
                cnt       <= cnt + 1'b1;
            end
        end
    end

    // Outputs are masked while rst is high so the reset cycle itself looks idle downstream.
    always_comb begin
        in_ready  = rst || !hold_full;
        bit_valid = !rst && (state == SHIFT);
        new_bit   = bit_valid && shift_reg[W-1];
        last_bit  = bit_valid && (cnt == LAST_CNT);
        fsm_rst   = rst || (state == CLEAR);
        busy      = !rst && ((state != IDLE) || hold_full);
    end

endmodule
